// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   - funct3 encodings for loads and stores
//   - FSM state and access-size enums
//   - byte-enable width
//   - helpers for access size, lane alignment and the misalignment predicate
package mem_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Any funct3 not naming a byte or half access behaves as a word access.
    function automatic size_e acc_size(input logic [2:0] mode, input logic is_store);
        size_e sz;
        sz = SZ_W;
        if (is_store) begin
            if (mode == F3_SB)      sz = SZ_B;
            else if (mode == F3_SH) sz = SZ_H;
        end else begin
            if (mode == F3_LB || mode == F3_LBU)      sz = SZ_B;
            else if (mode == F3_LH || mode == F3_LHU) sz = SZ_H;
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (sz)
            SZ_H:    mis = off[0];
            SZ_W:    mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Forces the byte offset to the natural alignment of the access size.
    function automatic logic [1:0] align_off(input size_e sz, input logic [1:0] off);
        logic [1:0] o;
        o = off;
        case (sz)
            SZ_H:    o = {off[1], 1'b0};
            SZ_W:    o = 2'b00;
            default: o = off;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational lane extraction and sign/zero extension of load data.
// Ports:
//   mode_i  - funct3 of the load
//   off_i   - byte offset within the word (already aligned to access size)
//   rdata_i - raw word returned by data memory
//   data_o  - extended write-back value
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      mode_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = shifted;
        case (mode_i)
            F3_LB:   data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LH:   data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline.
// Non-memory results are registered through in one cycle. Loads and stores run a
// req/gnt/rvalid handshake on the data port and stall upstream until complete.
// Build option: MEM_MISALIGN_TRAP_EN - misaligned half/word accesses are trapped
// (no bus request, misalign_o pulse) instead of being forced to natural alignment.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   valid_i .. mem_mode_i          - instruction from EXE/MEM register
//   stall_o                        - upstream hold (combinational)
//   dmem_*                         - data memory request/response port
//   valid_o, wb_val_o, rd_*_o      - write-back outputs (one-cycle valid pulse)
//   bus_err_o                      - access timed out
//   misalign_o                     - misaligned access trapped (trap build only)
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no access in flight; pass-through of ALU results
// REQ     | dmem_req_o held high, waiting for grant
// RESP    | load granted, waiting for rvalid
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RD_AW   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  alu_val_i,
    input  logic [XLEN-1:0]  rs2_val_i,
    input  logic [RD_AW-1:0] rd_addr_i,
    input  logic             rd_we_i,
    input  logic             mem_re_i,
    input  logic             mem_we_i,
    input  logic [2:0]       mem_mode_i,
    output logic             stall_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [XLEN-1:0]  dmem_addr_o,
    output logic [BE_W-1:0]  dmem_be_o,
    output logic [XLEN-1:0]  dmem_wdata_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic [XLEN-1:0]  dmem_rdata_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  wb_val_o,
    output logic [RD_AW-1:0] rd_addr_o,
    output logic             rd_we_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic             misalign_o,
`endif
    output logic             bus_err_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e           state_q;
    logic [TW-1:0]    cnt_q;
    logic [2:0]       mode_q;
    logic [1:0]       off_q;
    logic [RD_AW-1:0] rd_q;
    logic             rd_we_q;

    logic             mem_op;
    logic             trap;
    size_e            sz;
    logic [1:0]       off;
    logic [BE_W-1:0]  be_d;
    logic [XLEN-1:0]  wdata_d;
    logic [XLEN-1:0]  load_data;
    logic             tmo_hit;

    assign mem_op = valid_i & (mem_re_i | mem_we_i);
    assign sz     = acc_size(mem_mode_i, mem_we_i);
    assign off    = align_off(sz, alu_val_i[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = mem_op & is_misaligned(sz, alu_val_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Down-counter loaded on entry to REQ/RESP; terminal count at zero.
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == '0);

    always_comb begin
        be_d    = {BE_W{1'b1}};
        wdata_d = rs2_val_i;
        case (sz)
            SZ_B: begin
                be_d    = 4'b0001 << off;
                wdata_d = {4{rs2_val_i[7:0]}};
            end
            SZ_H: begin
                be_d    = 4'b0011 << {off[1], 1'b0};
                wdata_d = {2{rs2_val_i[15:0]}};
            end
            default: begin
                be_d    = {BE_W{1'b1}};
                wdata_d = rs2_val_i;
            end
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .mode_i  (mode_q),
        .off_i   (off_q),
        .rdata_i (dmem_rdata_i),
        .data_o  (load_data)
    );

    // A timeout also completes the instruction, so stall drops in the expiry
    // cycle; otherwise upstream would re-present the same op into IDLE.
    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            ST_IDLE: stall_o = mem_op & ~trap;
            ST_REQ:  stall_o = dmem_gnt_i ? ~dmem_we_o : ~tmo_hit;
            ST_RESP: stall_o = ~dmem_rvalid_i & ~tmo_hit;
            default: stall_o = 1'b0;
        endcase
        if (rst) stall_o = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mode_q       <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            rd_we_q      <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            valid_o      <= 1'b0;
            wb_val_o     <= '0;
            rd_addr_o    <= '0;
            rd_we_o      <= 1'b0;
            bus_err_o    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o   <= 1'b0;
`endif
        end else begin
            valid_o   <= 1'b0;
            bus_err_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (trap) begin
                        valid_o   <= 1'b1;
                        wb_val_o  <= alu_val_i;
                        rd_addr_o <= rd_addr_i;
                        rd_we_o   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_o <= 1'b1;
`endif
                    end else if (mem_op) begin
                        state_q      <= ST_REQ;
                        cnt_q        <= T_LOAD;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mem_we_i;
                        dmem_addr_o  <= {alu_val_i[XLEN-1:2], 2'b00};
                        dmem_be_o    <= be_d;
                        dmem_wdata_o <= wdata_d;
                        mode_q       <= mem_mode_i;
                        off_q        <= off;
                        rd_q         <= rd_addr_i;
                        rd_we_q      <= rd_we_i;
                    end else if (valid_i) begin
                        valid_o   <= 1'b1;
                        wb_val_o  <= alu_val_i;
                        rd_addr_o <= rd_addr_i;
                        rd_we_o   <= rd_we_i & (rd_addr_i != '0);
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (dmem_we_o) begin
                            state_q   <= ST_IDLE;
                            valid_o   <= 1'b1;
                            wb_val_o  <= '0;
                            rd_addr_o <= rd_q;
                            rd_we_o   <= 1'b0;
                        end else begin
                            state_q <= ST_RESP;
                            cnt_q   <= T_LOAD;
                        end
                    end else if (tmo_hit) begin
                        dmem_req_o <= 1'b0;
                        state_q    <= ST_IDLE;
                        valid_o    <= 1'b1;
                        bus_err_o  <= 1'b1;
                        wb_val_o   <= '0;
                        rd_addr_o  <= rd_q;
                        rd_we_o    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (dmem_rvalid_i) begin
                        state_q   <= ST_IDLE;
                        valid_o   <= 1'b1;
                        wb_val_o  <= load_data;
                        rd_addr_o <= rd_q;
                        rd_we_o   <= rd_we_q & (rd_q != '0);
                    end else if (tmo_hit) begin
                        state_q   <= ST_IDLE;
                        valid_o   <= 1'b1;
                        bus_err_o <= 1'b1;
                        wb_val_o  <= '0;
                        rd_addr_o <= rd_q;
                        rd_we_o   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
